// File: rtl/sdio_spi_target.sv
// Zorro II target for the SDIO card: 64 KB decode, local DTACK and an SPI-mode SD register file.
// Define SDIO_AUTOREAD_EN to make register 4 a read-and-clock-next-byte DATA alias.
module sdio_spi_target #(
    parameter logic [15:0] ID_WORD    = 16'h5D10,
    parameter logic [7:0]  CLKDIV_RST = 8'h31
) (
    input  logic        CLKCPU,
    input  logic        RESET_n,
    input  logic        AS_n,
    input  logic        UDS_n,
    input  logic        LDS_n,
    input  logic        RW_n,
    input  logic        BG_68SEC000_n,
    input  logic [7:0]  A_HIGH,
    input  logic [2:0]  A_LOW,
    input  logic [7:0]  BASE_SDIO,
    input  logic        SDIO_CONFIGURED_n,
    input  logic [15:0] D_IN,
    output logic [15:0] D_OUT,
    output logic        D_OE,
    output logic        DTACK_n,
    output logic        SDIO_ACCESS,
    output logic        SD_SCK,
    output logic        SD_MOSI,
    output logic        SD_CS_n,
    input  logic        SD_MISO,
    input  logic        SD_CD_n,
    input  logic        SD_WP
);

`ifdef SDIO_AUTOREAD_EN
    localparam bit AUTOREAD = 1'b1;
`else
    localparam bit AUTOREAD = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE = 2'd0, ACK = 2'd1, WAIT_AS = 2'd2} bus_state_e;

    bus_state_e  state_q, state_d;
    logic        strobe, bus_go, start_req, ev, done, go;
    logic [7:0]  start_tx, go_tx;
    logic        busy_q, busy_d, run_q, run_d, sck_q, sck_d, mosi_q, mosi_d;
    logic        pend_q, pend_d, ovr_q, ovr_d, cs_q, cs_d;
    logic [7:0]  cnt_q, cnt_d, div_l_q, div_l_d, sh_q, sh_d, rx_q, rx_d;
    logic [7:0]  pend_tx_q, pend_tx_d, clkdiv_q, clkdiv_d;
    logic [3:0]  half_q, half_d;
    logic [1:0]  cd_sync_q, cd_sync_d, wp_sync_q, wp_sync_d;
    logic        unused_d;

    assign unused_d    = ^{D_IN[15:9], D_IN[7:4]};
    assign strobe      = !UDS_n || !LDS_n;
    assign SDIO_ACCESS = !AS_n && BG_68SEC000_n && !SDIO_CONFIGURED_n && (A_HIGH == BASE_SDIO);
    assign D_OE        = SDIO_ACCESS && RW_n && strobe;

    // AS_n high clears the handshake at once, which also releases DTACK_n.
    always_ff @(posedge CLKCPU or negedge RESET_n or posedge AS_n) begin
        if (!RESET_n)  state_q <= IDLE;
        else if (AS_n) state_q <= IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (SDIO_ACCESS && strobe) state_d = ACK;
            ACK:     state_d = WAIT_AS;
            WAIT_AS: if (AS_n) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        DTACK_n = (state_q != WAIT_AS);
        bus_go  = (state_q == IDLE) && SDIO_ACCESS && strobe;
    end

    assign start_req = bus_go && ((!RW_n && A_LOW == 3'd0) || (AUTOREAD && RW_n && A_LOW == 3'd4));
    assign start_tx  = RW_n ? 8'hFF : D_IN[7:0];
    assign ev        = busy_q && run_q && (cnt_q == div_l_q);
    assign done      = ev && (half_q == 4'd15);

    always_comb begin
        busy_d    = busy_q;
        run_d     = run_q;
        cnt_d     = cnt_q;
        half_d    = half_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        sh_d      = sh_q;
        rx_d      = rx_q;
        div_l_d   = div_l_q;
        pend_d    = pend_q;
        pend_tx_d = pend_tx_q;
        ovr_d     = ovr_q;
        cs_d      = cs_q;
        clkdiv_d  = clkdiv_q;
        go        = 1'b0;
        go_tx     = 8'hFF;
        cd_sync_d = {cd_sync_q[0], SD_CD_n};
        wp_sync_d = {wp_sync_q[0], SD_WP};

        if (bus_go && !RW_n) begin
            case (A_LOW)
                3'd1: begin
                    if (!UDS_n) cs_d = D_IN[8];
                    if (!LDS_n && D_IN[3]) ovr_d = 1'b0;
                end
                3'd2: if (!LDS_n) clkdiv_d = D_IN[7:0];
                default: ;
            endcase
        end

        // The first busy cycle only arms the divider, so SCK rises div_l+1 cycles later.
        if (busy_q) begin
            if (!run_q) begin
                run_d = 1'b1;
                cnt_d = 8'd0;
            end else if (ev) begin
                cnt_d  = 8'd0;
                half_d = half_q + 4'd1;
                if (!half_q[0]) begin
                    sck_d = 1'b1;
                    sh_d  = {sh_q[6:0], SD_MISO};
                end else begin
                    sck_d = 1'b0;
                    if (done) begin
                        busy_d = 1'b0;
                        rx_d   = sh_q;
                        mosi_d = 1'b1;
                    end else begin
                        mosi_d = sh_q[7];
                    end
                end
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end

        // A request landing on the completion edge is held one cycle instead of overrunning.
        if (pend_q) begin
            go     = 1'b1;
            go_tx  = pend_tx_q;
            pend_d = 1'b0;
        end else if (start_req) begin
            if (!busy_q) begin
                go    = 1'b1;
                go_tx = start_tx;
            end else if (done) begin
                pend_d    = 1'b1;
                pend_tx_d = start_tx;
            end else begin
                ovr_d = 1'b1;
            end
        end

        if (go) begin
            busy_d  = 1'b1;
            run_d   = 1'b0;
            cnt_d   = 8'd0;
            half_d  = 4'd0;
            sck_d   = 1'b0;
            sh_d    = go_tx;
            mosi_d  = go_tx[7];
            div_l_d = clkdiv_q;
        end
    end

    always_ff @(posedge CLKCPU or negedge RESET_n) begin
        if (!RESET_n) begin
            busy_q    <= 1'b0;
            run_q     <= 1'b0;
            cnt_q     <= 8'd0;
            half_q    <= 4'd0;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b1;
            sh_q      <= 8'hFF;
            rx_q      <= 8'hFF;
            div_l_q   <= CLKDIV_RST;
            pend_q    <= 1'b0;
            pend_tx_q <= 8'hFF;
            ovr_q     <= 1'b0;
            cs_q      <= 1'b0;
            clkdiv_q  <= CLKDIV_RST;
            cd_sync_q <= 2'b11;
            wp_sync_q <= 2'b00;
        end else begin
            busy_q    <= busy_d;
            run_q     <= run_d;
            cnt_q     <= cnt_d;
            half_q    <= half_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            sh_q      <= sh_d;
            rx_q      <= rx_d;
            div_l_q   <= div_l_d;
            pend_q    <= pend_d;
            pend_tx_q <= pend_tx_d;
            ovr_q     <= ovr_d;
            cs_q      <= cs_d;
            clkdiv_q  <= clkdiv_d;
            cd_sync_q <= cd_sync_d;
            wp_sync_q <= wp_sync_d;
        end
    end

    assign SD_SCK  = sck_q;
    assign SD_MOSI = mosi_q;
    assign SD_CS_n = !cs_q;

    always_comb begin
        D_OUT = 16'h0000;
        case (A_LOW)
            3'd0: D_OUT = {8'h00, rx_q};
            3'd1: D_OUT = {7'd0, cs_q, 4'd0, ovr_q, wp_sync_q[1], !cd_sync_q[1], busy_q};
            3'd2: D_OUT = {8'h00, clkdiv_q};
            3'd3: D_OUT = ID_WORD;
            3'd4: D_OUT = AUTOREAD ? {8'h00, rx_q} : 16'h0000;
            default: D_OUT = 16'h0000;
        endcase
    end

endmodule

// File: tb/tb_sdio_spi_target.sv
// Directed bench for sdio_spi_target: bus decode/handshake, register file and SPI engine.
module tb_sdio_spi_target;
    logic        CLKCPU = 1'b0;
    logic        RESET_n, AS_n, UDS_n, LDS_n, RW_n, BG_68SEC000_n;
    logic [7:0]  A_HIGH, BASE_SDIO;
    logic [2:0]  A_LOW;
    logic        SDIO_CONFIGURED_n;
    logic [15:0] D_IN, D_OUT;
    logic        D_OE, DTACK_n, SDIO_ACCESS, SD_SCK, SD_MOSI, SD_CS_n;
    logic        SD_MISO, SD_CD_n, SD_WP;

    int          n_vec = 0;
    int          n_err = 0;
    int          nb, nr;
    logic [15:0] r;
    logic [7:0]  got, pat;
    logic        prev, all1;

    sdio_spi_target dut (
        .CLKCPU(CLKCPU), .RESET_n(RESET_n), .AS_n(AS_n), .UDS_n(UDS_n), .LDS_n(LDS_n),
        .RW_n(RW_n), .BG_68SEC000_n(BG_68SEC000_n), .A_HIGH(A_HIGH), .A_LOW(A_LOW),
        .BASE_SDIO(BASE_SDIO), .SDIO_CONFIGURED_n(SDIO_CONFIGURED_n), .D_IN(D_IN),
        .D_OUT(D_OUT), .D_OE(D_OE), .DTACK_n(DTACK_n), .SDIO_ACCESS(SDIO_ACCESS),
        .SD_SCK(SD_SCK), .SD_MOSI(SD_MOSI), .SD_CS_n(SD_CS_n), .SD_MISO(SD_MISO),
        .SD_CD_n(SD_CD_n), .SD_WP(SD_WP)
    );

    always #5 CLKCPU = ~CLKCPU;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic cyc();
        @(posedge CLKCPU);
        #1;
    endtask

    // One full 68000 cycle: first edge is the decode/write edge, DTACK_n expected on the second.
    task automatic bus(input logic rw, input logic [2:0] reg_a, input logic [15:0] wd,
                       input logic uds, input logic lds, output logic [15:0] rd);
        A_HIGH = 8'hE9; A_LOW = reg_a; RW_n = rw; D_IN = wd;
        UDS_n = uds; LDS_n = lds; AS_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (!DTACK_n) break;
        end
        chk("bus_dtack", 16'(DTACK_n), 16'h0000);
        rd = D_OUT;
        AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1; RW_n = 1'b1;
        cyc();
    endtask

    task automatic wr(input logic [2:0] reg_a, input logic [15:0] wd);
        logic [15:0] dummy;
        bus(1'b0, reg_a, wd, 1'b0, 1'b0, dummy);
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] reg_a, input logic [15:0] exp_v);
        logic [15:0] v;
        bus(1'b1, reg_a, 16'h0000, 1'b0, 1'b0, v);
        chk(tag, v, exp_v);
    endtask

    task automatic wait_idle();
        A_LOW = 3'd1;
        #1;
        for (int i = 0; i < 400; i++) begin
            if (!D_OUT[0]) break;
            cyc();
        end
        chk("idle_timeout", 16'(D_OUT[0]), 16'h0000);
    endtask

    task automatic miss(input string tag);
        A_LOW = 3'd3; RW_n = 1'b1; UDS_n = 1'b0; LDS_n = 1'b0; AS_n = 1'b0;
        #1;
        chk({tag, "_acc"}, 16'(SDIO_ACCESS), 16'h0000);
        chk({tag, "_oe"}, 16'(D_OE), 16'h0000);
        repeat (4) cyc();
        chk({tag, "_dtack"}, 16'(DTACK_n), 16'h0001);
        AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1;
        cyc();
    endtask

    initial begin
        RESET_n = 1'b0; AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1; RW_n = 1'b1;
        BG_68SEC000_n = 1'b1; A_HIGH = 8'hE9; A_LOW = 3'd0; BASE_SDIO = 8'hE9;
        SDIO_CONFIGURED_n = 1'b0; D_IN = 16'h0000; SD_MISO = 1'b1; SD_CD_n = 1'b0; SD_WP = 1'b1;
        repeat (3) cyc();
        chk("rst_cs_n", 16'(SD_CS_n), 16'h0001);
        chk("rst_sck", 16'(SD_SCK), 16'h0000);
        chk("rst_mosi", 16'(SD_MOSI), 16'h0001);
        chk("rst_dtack", 16'(DTACK_n), 16'h0001);
        chk("rst_doe", 16'(D_OE), 16'h0000);
        RESET_n = 1'b1;
        cyc();
        rd_chk("rst_clkdiv", 3'd2, 16'h0031);
        rd_chk("rst_id", 3'd3, 16'h5D10);
        rd_chk("rst_rx", 3'd0, 16'h00FF);
        rd_chk("rst_status", 3'd1, 16'h0006);

        // Hit: DTACK_n low on the 2nd edge, released by AS_n without a clock edge
        A_LOW = 3'd3; RW_n = 1'b1; UDS_n = 1'b0; LDS_n = 1'b0; AS_n = 1'b0;
        #1;
        chk("hit_acc", 16'(SDIO_ACCESS), 16'h0001);
        chk("hit_oe", 16'(D_OE), 16'h0001);
        cyc();
        chk("hit_dtack_e1", 16'(DTACK_n), 16'h0001);
        cyc();
        chk("hit_dtack_e2", 16'(DTACK_n), 16'h0000);
        chk("hit_id", D_OUT, 16'h5D10);
        AS_n = 1'b1;
        #1;
        chk("hit_release", 16'(DTACK_n), 16'h0001);
        chk("hit_oe_off", 16'(D_OE), 16'h0000);
        UDS_n = 1'b1; LDS_n = 1'b1;
        cyc();

        A_HIGH = 8'hEA; miss("miss_addr"); A_HIGH = 8'hE9;
        SDIO_CONFIGURED_n = 1'b1; miss("miss_cfg"); SDIO_CONFIGURED_n = 1'b0;
        BG_68SEC000_n = 1'b0; miss("miss_bg"); BG_68SEC000_n = 1'b1;

        // CLKDIV 0, TX A5, MISO 3C; write edge N, first sample N+2 (N+1 hidden by handshake)
        wr(3'd2, 16'h0000);
        pat = 8'h3C;
        SD_MISO = pat[7];
        wr(3'd0, 16'h00A5);
        A_LOW = 3'd1;
        #1;
        nb = 0; nr = 0; got = 8'h00; prev = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (SD_SCK && !prev) begin
                got = {got[6:0], SD_MOSI};
                if (nr < 7) SD_MISO = pat[6 - nr];
                nr++;
            end
            prev = SD_SCK;
            if (!D_OUT[0]) break;
            nb++;
            cyc();
        end
        chk("spi_mosi", 16'(got), 16'h00A5);
        chk("spi_rises", 16'(nr), 16'd8);
        chk("spi_busy_n2_n16", 16'(nb), 16'd15);
        chk("spi_sck_end", 16'(SD_SCK), 16'h0000);
        chk("spi_mosi_idle", 16'(SD_MOSI), 16'h0001);
        rd_chk("spi_rx", 3'd0, 16'h003C);

        // Write landing on the completion edge (M+17) is deferred, not overrun
        SD_MISO = 1'b0;
        wr(3'd0, 16'h005A);
        repeat (14) cyc();
        SD_MISO = 1'b1;
        wr(3'd0, 16'h0011);
        rd_chk("pend_status", 3'd1, 16'h0007);
        wait_idle();
        rd_chk("pend_rx", 3'd0, 16'h00FF);

        // CLKDIV 3: first SCK rise at N+5; second write at N+3 overruns
        wr(3'd2, 16'h0003);
        wr(3'd0, 16'h0011);
        chk("div3_sck_lo", 16'(SD_SCK), 16'h0000);
        wr(3'd0, 16'h0022);
        chk("div3_sck_hi", 16'(SD_SCK), 16'h0001);
        rd_chk("ovr_set", 3'd1, 16'h000F);
        wait_idle();
        rd_chk("ovr_idle", 3'd1, 16'h000E);
        wr(3'd1, 16'h0008);
        rd_chk("ovr_clr", 3'd1, 16'h0006);

        // Byte-lane qualification of CS and CLKDIV writes
        bus(1'b0, 3'd1, 16'h0100, 1'b1, 1'b0, r);
        chk("cs_lds_only", 16'(SD_CS_n), 16'h0001);
        bus(1'b0, 3'd1, 16'h0100, 1'b0, 1'b1, r);
        chk("cs_uds", 16'(SD_CS_n), 16'h0000);
        rd_chk("cs_status", 3'd1, 16'h0106);
        bus(1'b0, 3'd2, 16'h0055, 1'b0, 1'b1, r);
        rd_chk("clkdiv_lds_hi", 3'd2, 16'h0003);

        // Register 4: autoread alias or plain zero
`ifdef SDIO_AUTOREAD_EN
        rd_chk("reg4_read", 3'd4, 16'h00FF);
`else
        rd_chk("reg4_read", 3'd4, 16'h0000);
`endif
        nr = 0; all1 = 1'b1; prev = SD_SCK;
        for (int i = 0; i < 200; i++) begin
            cyc();
            if (SD_SCK && !prev) begin
                nr++;
                if (!SD_MOSI) all1 = 1'b0;
            end
            prev = SD_SCK;
        end
`ifdef SDIO_AUTOREAD_EN
        chk("reg4_rises", 16'(nr), 16'd8);
`else
        chk("reg4_rises", 16'(nr), 16'd0);
`endif
        chk("reg4_mosi", 16'(all1), 16'h0001);

        // Reset in the middle of a transfer (SCK high, MOSI 0, CS asserted)
        SD_MISO = 1'b0;
        wr(3'd0, 16'h0000);
        repeat (3) cyc();
        chk("mid_sck_pre", 16'(SD_SCK), 16'h0001);
        RESET_n = 1'b0;
        #1;
        chk("mid_rst_sck", 16'(SD_SCK), 16'h0000);
        chk("mid_rst_mosi", 16'(SD_MOSI), 16'h0001);
        chk("mid_rst_cs", 16'(SD_CS_n), 16'h0001);
        cyc();
        RESET_n = 1'b1;
        cyc();
        rd_chk("mid_status", 3'd1, 16'h0006);
        rd_chk("mid_rx", 3'd0, 16'h00FF);
        rd_chk("mid_clkdiv", 3'd2, 16'h0031);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
